run_controller: RTL and testbench

- Host-side launch-and-measure stage directly upstream of the processor TopLevel.
- Accepts a run request, drives TopLevel's `start` pulse, then watches `halt`.
- Reports completion with a cycle count, and flags timeout or abort.
- Replaces hand-timed start/stop sequencing; the bench and any future host sequencer sit on its request side.

---
 rtl/run_ctrl_pkg.sv | 5 +
 rtl/run_cycle_counter.sv | 21 ++
 rtl/run_controller.sv | 127 ++++++++++++
 tb/tb_run_controller.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and sub-counter widths for run_controller.
package run_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} run_state_t;
    localparam int unsigned SUB_W = 4;
endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter: RUN-cycle counter with a terminal flag at TIMEOUT.
module run_cycle_counter #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : enable ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign count    = cnt_q;
    assign at_limit = cnt_q == CNT_W'(TIMEOUT);
endmodule

// File: rtl/run_controller.sv
// run_controller: launches a TopLevel run with a start pulse, measures it until
// halt, and reports completion with cycle count and timeout/abort status.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 16'hFFFF,
    parameter int unsigned START_LEN = 1,
    parameter int unsigned BLANK     = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             run_req,
    input  logic             abort,
    output logic             run_ack,
    output logic             start,
    input  logic             halt,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic             aborted,
    output logic [CNT_W-1:0] cycle_count
);
    run_state_t       state_q, state_d;
    logic [SUB_W-1:0] len_q, len_d;
    logic             run_ack_q, run_ack_d, start_q, start_d, busy_q, busy_d;
    logic             done_q, done_d, to_q, to_d, ab_q, ab_d;
    logic [CNT_W-1:0] cc_q, cc_d, n;
    logic             clr, en, at_lim, halt_ok;

    run_cycle_counter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_cnt (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clear    (clr),
        .enable   (en),
        .count    (n),
        .at_limit (at_lim)
    );

    // A halt still asserted from the previous program is masked for BLANK cycles
    assign halt_ok = halt && (n > CNT_W'(BLANK));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        run_ack_d = 1'b0;
        start_d   = start_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        to_d      = to_q;
        ab_d      = ab_q;
        cc_d      = cc_q;
        clr       = 1'b0;
        en        = 1'b0;
        case (state_q)
            IDLE: if (run_req) begin
                state_d   = LAUNCH;
                run_ack_d = 1'b1;
                start_d   = 1'b1;
                busy_d    = 1'b1;
                to_d      = 1'b0;
                ab_d      = 1'b0;
                clr       = 1'b1;
                len_d     = SUB_W'(1);
            end
            LAUNCH: if (abort) begin
                state_d = DONE;
                start_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                ab_d    = 1'b1;
                cc_d    = '0;
            end else if (len_q == SUB_W'(START_LEN)) begin
                state_d = RUN;
                start_d = 1'b0;
                en      = 1'b1;
            end else begin
                len_d = len_q + SUB_W'(1);
            end
            // Exit priority: halt, then abort, then timeout
            RUN: if (halt_ok || abort || at_lim) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cc_d    = n;
                to_d    = !halt_ok && !abort;
                ab_d    = !halt_ok && abort;
            end else begin
                en = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            len_q     <= '0;
            run_ack_q <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            ab_q      <= 1'b0;
            cc_q      <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            run_ack_q <= run_ack_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            to_q      <= to_d;
            ab_q      <= ab_d;
            cc_q      <= cc_d;
        end
    end

    assign run_ack     = run_ack_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timed_out   = to_q;
    assign aborted     = ab_q;
    assign cycle_count = cc_q;
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed and randomized runs against a per-run outcome model.
module tb_run_controller;
    localparam int SL = 4;
    localparam int BL = 2;
    localparam int TO = 20;

    logic        clk = 1'b0, rst_n = 1'b1, run_req = 1'b0, abort = 1'b0, halt = 1'b0;
    logic        run_ack, start, busy, done, timed_out, aborted;
    logic [15:0] cycle_count;
    int          passed = 0, failed = 0, total = 0, ecnt = 0;
    int          prev_cnt = 0, last_ack = 0, last_gap = 0;
    bit          last_keep = 0;

    run_controller #(.CNT_W(16), .TIMEOUT(TO), .START_LEN(SL), .BLANK(BL)) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .run_req     (run_req),
        .abort       (abort),
        .run_ack     (run_ack),
        .start       (start),
        .halt        (halt),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .aborted     (aborted),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input bit ack, input bit st, input bit bz,
                              input bit dn, input bit tout, input bit abt, input int cnt);
        chk({tag, ".ctl"}, {26'd0, run_ack, start, busy, done, timed_out, aborted},
            {26'd0, ack, st, bz, dn, tout, abt});
        chk({tag, ".cnt"}, {16'd0, cycle_count}, cnt);
    endtask

    // halt_from: first RUN cycle n with halt high (0 = never); abort_at: RUN cycle n
    // with abort; abort_l: LAUNCH cycle (1-based) with abort; called from an IDLE cycle.
    task automatic do_run(input string name, input int halt_from, input int abort_at,
                          input int abort_l, input bit keep);
        int  end_c, n_end, cnt, n;
        bit  tout, abt, fin;
        tout = 0; abt = 0; n_end = 0;
        if (abort_l >= 1 && abort_l <= SL) begin
            end_c = abort_l - 1;
            cnt   = 0;
            abt   = 1;
        end else begin
            for (int k = 1; k <= TO && n_end == 0; k++) begin
                if (halt_from > 0 && k >= halt_from && k > BL) n_end = k;
                else if (k == abort_at) begin n_end = k; abt = 1; end
                else if (k == TO) begin n_end = k; tout = 1; end
            end
            cnt   = n_end;
            end_c = SL - 1 + n_end;
        end
        run_req = 1'b1;
        cyc();
        if (!keep) run_req = 1'b0;
        for (int c = 0; c <= end_c + 1; c++) begin
            n   = c - SL + 1;
            fin = c > end_c;
            expect_out($sformatf("%s.c%0d", name, c), c == 0, !fin && c < SL, !fin, fin,
                       fin ? tout : 1'b0, fin ? abt : 1'b0, fin ? cnt : prev_cnt);
            if (c == 0) begin
                if (last_keep) chk({name, ".gap"}, ecnt - last_ack, last_gap);
                last_ack = ecnt;
            end
            if (fin) begin
                halt  = 1'($urandom);
                abort = 1'($urandom);
            end else if (c < SL) begin
                halt  = (halt_from == 1) ? 1'b1 : 1'($urandom);
                abort = (c + 1 == abort_l);
            end else begin
                halt  = halt_from > 0 && n >= halt_from;
                abort = (n == abort_at);
            end
            cyc();
        end
        prev_cnt = cnt;
        expect_out({name, ".idle"}, 0, 0, 0, 0, tout, abt, cnt);
        halt      = 1'b0;
        abort     = 1'b0;
        last_keep = keep;
        last_gap  = end_c + 3;
    endtask

    initial begin
        int hf, aa, al;
        bit kp;
        #2 rst_n = 1'b0;
        repeat (3) cyc();
        expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            expect_out($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0, 0);
        end

        do_run("normal",    7,  0, 0, 0);
        do_run("blank",     1,  0, 0, 0);
        do_run("timeout",   0,  0, 0, 0);
        do_run("halt_at_to", TO, 0, 0, 0);
        do_run("abort_l2",  0,  0, 2, 0);
        do_run("abort_halt", 5, 5, 0, 0);
        do_run("abort_run", 0,  6, 0, 0);
        do_run("abort_blank", 1, 1, 0, 0);

        run_req = 1'b1;
        cyc();
        run_req = 1'b0;
        repeat (SL - 1 + 10) cyc();
        #2 rst_n = 1'b0;
        #1 expect_out("async_rst", 0, 0, 0, 0, 0, 0, 0);
        cyc();
        expect_out("rst_hold0", 0, 0, 0, 0, 0, 0, 0);
        cyc();
        expect_out("rst_hold1", 0, 0, 0, 0, 0, 0, 0);
        rst_n     = 1'b1;
        prev_cnt  = 0;
        last_keep = 0;
        cyc();

        do_run("b2b0", 3, 0, 0, 1);
        do_run("b2b1", 3, 0, 0, 1);
        do_run("b2b2", 3, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            hf = $urandom_range(0, 24);
            aa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 22) : 0;
            al = ($urandom_range(0, 5) == 0) ? $urandom_range(1, SL) : 0;
            kp = (i < 24) && ($urandom_range(0, 1) == 1);
            do_run($sformatf("rnd%0d", i), hf, aa, al, kp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
